// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory MMIO bridge: register offsets,
// STATUS bit positions and the default I/O region base.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DFLT = 32'h8000_0000;

  localparam logic [11:0] MMIO_TXDATA   = 12'h000;
  localparam logic [11:0] MMIO_STATUS   = 12'h004;
  localparam logic [11:0] MMIO_CYCLE_LO = 12'h008;
  localparam logic [11:0] MMIO_CYCLE_HI = 12'h00C;

  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_FULL_BIT  = 8;
  localparam int STATUS_EMPTY_BIT = 9;
  localparam int STATUS_OVF_BIT   = 31;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. Storage is not reset; only pointers and count
// are. A push into a full FIFO is dropped and flagged on overflow, unless a
// pop in the same cycle makes room.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign rdata    = mem_q[rd_q];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && !push_ok;

  // Next pointer/count values from the accepted push and pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Splits core data accesses between external RAM and a small I/O region
// holding a console TX FIFO and a free-running 64-bit cycle counter.
// Read data is combinational so the core's memory stage sees it same-cycle.
module dmem_mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_write_byte_i,
  input  logic        dmem_read_i,
  output logic [31:0] dmem_rdata_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_write_byte_o,
  output logic        ram_read_o,
  input  logic [31:0] ram_rdata_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          is_mmio, is_write;
  logic [11:0]   offset;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic          ovf_q, ovf_d, ovf_clr;
  logic [63:0]   cycle_q, cycle_d;
  logic [31:0]   mmio_rdata;

  assign is_mmio  = (dmem_addr_i[31:12] == MMIO_BASE[31:12]);
  assign is_write = |dmem_write_byte_i;
  assign offset   = {dmem_addr_i[11:2], 2'b00};

  assign ram_addr_o       = dmem_addr_i;
  assign ram_wdata_o      = dmem_wdata_i;
  assign ram_write_byte_o = is_mmio ? 4'b0000 : dmem_write_byte_i;
  assign ram_read_o       = dmem_read_i && !is_mmio;

  assign fifo_push  = is_mmio && (offset == MMIO_TXDATA) && dmem_write_byte_i[0];
  assign fifo_pop   = tx_valid_o && tx_ready_i;
  assign ovf_clr    = is_mmio && (offset == MMIO_STATUS) && is_write;
  assign tx_valid_o = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .wdata    (dmem_wdata_i[7:0]),
    .pop      (fifo_pop),
    .rdata    (tx_data_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  // Sticky overflow: a dropped push sets it, any STATUS write clears it.
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_ovf)     ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Cycle counter wraps naturally at 2^64.
  always_comb begin
    cycle_d = cycle_q + 64'd1;
  end

  // Overflow flag and cycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  // I/O register read mux; TXDATA and unmapped offsets read as zero.
  always_comb begin
    mmio_rdata = '0;
    case (offset)
      MMIO_STATUS: begin
        mmio_rdata[STATUS_COUNT_LSB +: 8] = 8'(fifo_count);
        mmio_rdata[STATUS_FULL_BIT]       = fifo_full;
        mmio_rdata[STATUS_EMPTY_BIT]      = fifo_empty;
        mmio_rdata[STATUS_OVF_BIT]        = ovf_q;
      end
      MMIO_CYCLE_LO: mmio_rdata = cycle_q[31:0];
      MMIO_CYCLE_HI: mmio_rdata = cycle_q[63:32];
      default:       mmio_rdata = '0;
    endcase
  end

  // Core read data: RAM or I/O depending on decode, zero when not reading.
  always_comb begin
    dmem_rdata_o = '0;
    if (dmem_read_i) dmem_rdata_o = is_mmio ? mmio_rdata : ram_rdata_i;
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: RAM pass-through, TX FIFO push/drain,
// overflow, full push+pop, cycle counter and mid-drain reset.
module tb_dmem_mmio_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [3:0]  dmem_write_byte_i;
  logic        dmem_read_i;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [3:0]  ram_write_byte_o;
  logic        ram_read_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, tx_ready_i;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CLO = 32'h8000_0008;
  localparam logic [31:0] A_CHI = 32'h8000_000C;

  always #5 clk = ~clk;

  dmem_mmio_bridge #(.FIFO_DEPTH(8), .MMIO_BASE(32'h8000_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .dmem_addr_i       (dmem_addr_i),
    .dmem_wdata_i      (dmem_wdata_i),
    .dmem_write_byte_i (dmem_write_byte_i),
    .dmem_read_i       (dmem_read_i),
    .dmem_rdata_o      (dmem_rdata_o),
    .ram_addr_o        (ram_addr_o),
    .ram_wdata_o       (ram_wdata_o),
    .ram_write_byte_o  (ram_write_byte_o),
    .ram_read_o        (ram_read_o),
    .ram_rdata_i       (ram_rdata_i),
    .tx_data_o         (tx_data_o),
    .tx_valid_o        (tx_valid_o),
    .tx_ready_i        (tx_ready_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write commits at the next posedge, returns at the following negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    dmem_addr_i = a; dmem_wdata_i = d; dmem_write_byte_i = be; dmem_read_i = 1'b0;
    @(negedge clk);
    dmem_write_byte_i = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dmem_addr_i = a; dmem_write_byte_i = 4'b0000; dmem_read_i = 1'b1;
    #1 d = dmem_rdata_o;
  endtask

  logic [31:0] r;
  logic [7:0]  exp_bytes [8];

  initial begin
    reset = 1'b1;
    dmem_addr_i = '0; dmem_wdata_i = '0; dmem_write_byte_i = '0; dmem_read_i = 1'b0;
    ram_rdata_i = '0; tx_ready_i = 1'b0;

    @(negedge clk);
    #1 chk("reset_tx_valid", tx_valid_o, 1'b0);
    rd(A_ST, r); chk("reset_status", r, 32'h0000_0200);
    reset = 1'b0;
    rd(A_CLO, r); chk("cycle_lo_first", r, 32'd0);
    repeat (10) @(negedge clk);
    rd(A_CLO, r); chk("cycle_lo_10", r, 32'd10);
    rd(A_CHI, r); chk("cycle_hi_10", r, 32'd0);

    // RAM pass-through
    @(negedge clk);
    dmem_addr_i = 32'h0000_0100; dmem_wdata_i = 32'hDEAD_BEEF; dmem_write_byte_i = 4'b0011;
    #1 chk("ram_wbe", ram_write_byte_o, 4'b0011);
    chk("ram_addr", ram_addr_o, 32'h0000_0100);
    chk("ram_wdata", ram_wdata_o, 32'hDEAD_BEEF);
    dmem_write_byte_i = 4'b0000; dmem_read_i = 1'b1; ram_rdata_i = 32'h1234_5678;
    #1 chk("ram_rdata", dmem_rdata_o, 32'h1234_5678);
    chk("ram_read", ram_read_o, 1'b1);
    dmem_addr_i = A_ST; dmem_write_byte_i = 4'b1111;
    #1 chk("mmio_gate_wbe", ram_write_byte_o, 4'b0000);
    chk("mmio_gate_read", ram_read_o, 1'b0);
    chk("mmio_status_rd", dmem_rdata_o, 32'h0000_0200);
    dmem_write_byte_i = 4'b0000; dmem_read_i = 1'b0; dmem_addr_i = 32'h0000_0100;
    #1 chk("no_read_zero", dmem_rdata_o, 32'd0);

    // Push A,B,C without drain
    @(negedge clk);
    wr(A_TX, 32'h41, 4'b0001);
    wr(A_TX, 32'h42, 4'b0001);
    wr(A_TX, 32'h43, 4'b0001);
    rd(A_ST, r); chk("status_3", r, 32'h0000_0003);
    rd(A_TX, r); chk("txdata_reads_0", r, 32'd0);
    chk("valid_after_push", tx_valid_o, 1'b1);

    // Drain
    tx_ready_i = 1'b1;
    #1 chk("drain_0", tx_data_o, 8'h41);
    @(negedge clk); #1 chk("drain_1", tx_data_o, 8'h42);
    @(negedge clk); #1 chk("drain_2", tx_data_o, 8'h43);
    @(negedge clk); #1 chk("drain_done_valid", tx_valid_o, 1'b0);
    rd(A_ST, r); chk("drain_done_status", r, 32'h0000_0200);
    tx_ready_i = 1'b0;

    // Overflow: nine pushes into eight entries
    @(negedge clk);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h30 + i, 4'b0001);
    rd(A_ST, r); chk("status_ovf", r, 32'h8000_0108);
    wr(A_ST, 32'h0, 4'b1111);
    rd(A_ST, r); chk("status_ovf_clr", r, 32'h0000_0108);

    // Full with simultaneous push and pop
    @(negedge clk);
    dmem_addr_i = A_TX; dmem_wdata_i = 32'h55; dmem_write_byte_i = 4'b0001; dmem_read_i = 1'b0;
    tx_ready_i = 1'b1;
    #1 chk("full_pp_head", tx_data_o, 8'h30);
    @(negedge clk);
    dmem_write_byte_i = 4'b0000; tx_ready_i = 1'b0;
    rd(A_ST, r); chk("full_pp_status", r, 32'h0000_0108);
    exp_bytes[0] = 8'h31; exp_bytes[1] = 8'h32; exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h34;
    exp_bytes[4] = 8'h35; exp_bytes[5] = 8'h36; exp_bytes[6] = 8'h37; exp_bytes[7] = 8'h55;
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("full_pp_drain_%0d", i), tx_data_o, exp_bytes[i]);
      @(negedge clk);
    end
    #1 chk("full_pp_empty", tx_valid_o, 1'b0);
    tx_ready_i = 1'b0;

    // Counter wrap
    @(negedge clk);
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    release dut.cycle_q;
    rd(A_CLO, r); chk("wrap_pre_lo", r, 32'hFFFF_FFFF);
    @(negedge clk);
    rd(A_CLO, r); chk("wrap_lo", r, 32'd0);
    rd(A_CHI, r); chk("wrap_hi", r, 32'd0);

    // Reset in the middle of a drain
    @(negedge clk);
    wr(A_TX, 32'h61, 4'b0001);
    wr(A_TX, 32'h62, 4'b0001);
    wr(A_TX, 32'h63, 4'b0001);
    tx_ready_i = 1'b1;
    @(negedge clk);
    #1 chk("mid_drain_data", tx_data_o, 8'h62);
    #1 reset = 1'b1;
    #1 chk("reset_valid_drop", tx_valid_o, 1'b0);
    rd(A_ST, r); chk("reset_status_mid", r, 32'h0000_0200);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1 chk("post_reset_valid", tx_valid_o, 1'b0);
    rd(A_CLO, r); chk("post_reset_cycle", r, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
